// File: rtl/booth_mul_pkg.sv
// Shared types and default sizes for the Booth multiplier arbiter.
// State encoding is fixed at 3 bits so it stays the same across builds.
package booth_mul_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      RUN       = 3'd3,
      RESP      = 3'd4
   } state_t;

   localparam int N_REQ_DEF   = 4;
   localparam int W_DEF       = 16;
   localparam int TIMEOUT_DEF = 40;

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around. The output grant is one-hot, or zero when enable is low.
module rr_arbiter
   import booth_mul_pkg::*;
#(
   parameter  int N_REQ = N_REQ_DEF,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   input  logic             enable,
   output logic [N_REQ-1:0] grant,
   output logic [IDW-1:0]   index,
   output logic             any_req
);

   logic [IDW:0]   cand;
   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // ptr + k never exceeds 2*N_REQ-2, so a single subtract wraps it
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N_REQ))
            cand = cand - (IDW+1)'(N_REQ);
         idx = cand[IDW-1:0];
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            index      = idx;
            found      = 1'b1;
         end
      end
   end

   assign any_req = enable && (|req);

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential signed multiplier between N_REQ requesters with a
// round-robin grant, one operation in flight, and a per-phase timeout.
module booth_mul_arbiter
   import booth_mul_pkg::*;
#(
   parameter  int N_REQ   = N_REQ_DEF,
   parameter  int W       = W_DEF,
   parameter  int TIMEOUT = TIMEOUT_DEF,
   localparam int IDW     = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_x,
   input  logic [N_REQ*W-1:0] req_y,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*W-1:0]     rsp_z,
   output logic [IDW-1:0]     rsp_id,
   output logic               rsp_err,
   output logic [W-1:0]       mul_x,
   output logic [W-1:0]       mul_y,
   output logic               mul_start,
   input  logic [2*W-1:0]     mul_z,
   input  logic               mul_busy,
   output logic               ctl_busy
);

   localparam int TW = $clog2(TIMEOUT+1);

   state_t         state_reg;
   logic [IDW-1:0] rr_ptr_reg;
   logic [IDW-1:0] id_reg;
   logic [TW-1:0]  timer_reg;
   logic [IDW-1:0] gidx;
   logic           any_req;
   logic           arb_en;
   logic           timer_last;

   // Grants are only offered in IDLE and never while reset is asserted
   assign arb_en     = rst_n && (state_reg == IDLE);
   assign timer_last = (timer_reg == TW'(TIMEOUT-1));
   assign rsp_id     = id_reg;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_reg),
      .enable  (arb_en),
      .grant   (req_ready),
      .index   (gidx),
      .any_req (any_req)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         id_reg     <= '0;
         timer_reg  <= '0;
         mul_x      <= '0;
         mul_y      <= '0;
         mul_start  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_z      <= '0;
         rsp_err    <= 1'b0;
         ctl_busy   <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  mul_x      <= req_x[gidx*W +: W];
                  mul_y      <= req_y[gidx*W +: W];
                  id_reg     <= gidx;
                  rr_ptr_reg <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + IDW'(1);
                  mul_start  <= 1'b1;
                  ctl_busy   <= 1'b1;
                  state_reg  <= ISSUE;
               end
            end
            ISSUE: begin
               timer_reg <= '0;
               state_reg <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (mul_busy) begin
                  timer_reg <= '0;
                  state_reg <= RUN;
               end else if (timer_last) begin
                  rsp_z     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_reg <= RESP;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            RUN: begin
               if (!mul_busy) begin
                  rsp_z     <= mul_z;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state_reg <= RESP;
               end else if (timer_last) begin
                  rsp_z     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_reg <= RESP;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ctl_busy  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
               ctl_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier, grant/response
// scoreboard, vector table plus backpressure, timeout and reset sequences.
module tb_booth_mul_arbiter;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int TO  = 40;
   localparam int LAT = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_x = '0;
   logic [N*W-1:0]  req_y = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic [2*W-1:0]  rsp_z;
   logic [1:0]      rsp_id;
   logic            rsp_err;
   logic [W-1:0]    mul_x;
   logic [W-1:0]    mul_y;
   logic            mul_start;
   logic [2*W-1:0]  mul_z;
   logic            mul_busy;
   logic            ctl_busy;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_start (mul_start),
      .mul_z     (mul_z),
      .mul_busy  (mul_busy),
      .ctl_busy  (ctl_busy)
   );

   // Behavioural multiplier: busy the cycle after start, LAT cycles long
   logic        stuck = 1'b0;
   int          mcnt;
   logic [31:0] mprod;

   function automatic logic [31:0] smul(logic [15:0] a, logic [15:0] b);
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_busy <= 1'b0;
         mul_z    <= '0;
         mcnt     <= 0;
         mprod    <= '0;
      end else if (mul_start && !stuck) begin
         mul_busy <= 1'b1;
         mcnt     <= LAT;
         mprod    <= smul(mul_x, mul_y);
      end else if (mul_busy) begin
         if (mcnt == 1) begin
            mul_busy <= 1'b0;
            mul_z    <= mprod;
         end
         mcnt <= mcnt - 1;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] z;
      logic [1:0]  id;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   int          grant_log[$];
   logic [31:0] exp_z[N];
   logic        exp_err = 1'b0;
   int          mptr = 0;
   int          cyc = 0;
   int          start_cnt = 0;
   int          rsp_seen = 0;
   int          last_start_cyc = 0;
   int          last_rsp_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: grant check against a round-robin model, scoreboard on responses
   always @(negedge clk) begin
      int   eg;
      int   g;
      exp_t e;
      if (!rst_n) begin
         sbq.delete();
         mptr = 0;
      end else begin
         if (mul_start) begin
            start_cnt++;
            last_start_cyc = cyc;
         end
         if (ctl_busy && req_valid != '0)
            chk("ready_while_busy", 64'(req_ready), 64'(0));
         if (req_ready != '0) begin
            eg = -1;
            for (int k = N-1; k >= 0; k--)
               if (req_valid[(mptr + k) % N]) eg = (mptr + k) % N;
            g = 0;
            for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
            chk("grant", 64'(req_ready), (eg >= 0) ? 64'(1) << eg : 64'(0));
            e.z   = exp_z[g];
            e.id  = 2'(g);
            e.err = exp_err;
            sbq.push_back(e);
            grant_log.push_back(g);
            mptr = (g + 1) % N;
         end
         if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            last_rsp_cyc = cyc;
            $display("rsp id=%0d z=%h err=%b @cyc %0d", rsp_id, rsp_z, rsp_err, cyc);
            if (sbq.size() == 0) begin
               chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
               e = sbq.pop_front();
               chk("rsp_z", 64'(rsp_z), 64'(e.z));
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
            end
         end
      end
   end

   task automatic set_req(int i, logic [15:0] x, logic [15:0] y);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
      req_valid[i]    = 1'b1;
   endtask

   task automatic wait_grant(int i);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready[i] && n < 200);
      chk($sformatf("grant_seen_%0d", i), 64'(req_ready[i]), 64'(1));
      @(posedge clk);
      #1 req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(int target);
      int n = 0;
      while (rsp_seen < target && n < 300) begin
         @(negedge clk);
         #1 n++;
      end
      chk("rsp_count", 64'(rsp_seen), 64'(target));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      int          id;
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] z;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int target;
      int n;
      target = 0;
      vecs[0] = '{0, 16'd3,    16'd5,    32'd15};
      vecs[1] = '{1, 16'hFFF9, 16'd6,    32'hFFFF_FFD6};
      vecs[2] = '{2, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      vecs[3] = '{3, 16'h8000, 16'h8000, 32'h4000_0000};
      vecs[4] = '{0, 16'h8000, 16'h7FFF, 32'hC000_8000};
      vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
      vecs[6] = '{2, 16'h0000, 16'h1234, 32'h0000_0000};
      vecs[7] = '{3, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
      for (int i = 0; i < N; i++) exp_z[i] = '0;

      // Reset state, with a request pending that must not be granted
      req_valid = 4'b0001;
      #12;
      chk("reset_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err, mul_start, ctl_busy}), 64'(0));
      chk("reset_data", {rsp_z, mul_x, mul_y}, 64'(0));
      req_valid = '0;
      do_reset();

      // Vector table, one request at a time
      foreach (vecs[v]) begin
         @(posedge clk);
         #1;
         exp_z[vecs[v].id] = vecs[v].z;
         start_cnt = 0;
         set_req(vecs[v].id, vecs[v].x, vecs[v].y);
         wait_grant(vecs[v].id);
         target++;
         wait_rsp(target);
         chk("start_pulses", 64'(start_cnt), 64'(1));
      end

      // Round-robin with all four requesters continuously valid
      do_reset();
      grant_log.delete();
      @(posedge clk);
      #1;
      exp_z[0] = 32'd2;  exp_z[1] = 32'd6;  exp_z[2] = 32'd12; exp_z[3] = 32'd20;
      set_req(0, 16'd1, 16'd2);
      set_req(1, 16'd2, 16'd3);
      set_req(2, 16'd3, 16'd4);
      set_req(3, 16'd4, 16'd5);
      n = 0;
      while (grant_log.size() < 5 && n < 400) begin
         @(negedge clk);
         #1 n++;
      end
      @(posedge clk);
      #1 req_valid = '0;
      target += 5;
      wait_rsp(target);
      chk("rr_count", 64'(grant_log.size()), 64'(5));
      for (int k = 0; k < 5 && k < grant_log.size(); k++)
         chk($sformatf("rr_order_%0d", k), 64'(grant_log[k]), 64'(k % N));

      // Backpressure: response held while another requester waits
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      exp_z[2] = 32'd12;
      exp_z[3] = 32'd100;
      set_req(2, 16'hFFFD, 16'hFFFC);
      wait_grant(2);
      set_req(3, 16'd10, 16'd10);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 200);
      #1 start_cnt = 0;
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid", 64'(rsp_valid), 64'(1));
         chk("bp_z", 64'(rsp_z), 64'(32'd12));
         chk("bp_id", 64'(rsp_id), 64'(2));
         chk("bp_ready", 64'(req_ready), 64'(0));
      end
      chk("bp_no_start", 64'(start_cnt), 64'(0));
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_grant(3);
      target += 2;
      wait_rsp(target);

      // Multiplier never goes busy: timeout response
      @(posedge clk);
      #1;
      stuck   = 1'b1;
      exp_err = 1'b1;
      exp_z[0] = 32'd0;
      set_req(0, 16'd3, 16'd3);
      wait_grant(0);
      target++;
      wait_rsp(target);
      chk("timeout_latency", 64'(last_rsp_cyc - last_start_cyc), 64'(TO + 1));
      @(posedge clk);
      #1;
      stuck   = 1'b0;
      exp_err = 1'b0;

      // Reset asserted while the multiplier is running
      exp_z[1] = 32'd45;
      set_req(1, 16'd5, 16'd9);
      wait_grant(1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mul_busy && n < 100);
      @(negedge clk);
      chk("run_busy", 64'({ctl_busy, mul_busy}), 64'(3));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctl", 64'({req_ready, rsp_valid, rsp_id, rsp_err, mul_start, ctl_busy}), 64'(0));
      chk("midrst_data", {rsp_z, mul_x, mul_y}, 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_z[1] = 32'hFFFF_FF38;
      set_req(1, 16'd100, 16'hFFFE);
      wait_grant(1);
      target++;
      wait_rsp(target);
      chk("sb_empty", 64'(sbq.size()), 64'(0));

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
